shared_ram_arb: RTL and testbench

- Parametrised dual-CPU shared RAM for the main/sub CPU pair.
- Replaces halt-only main access with a request/acknowledge arbiter, so both CPUs reach the RAM without halting the sub CPU.
- Keeps legacy exclusive-main mode while SHALTACn is low.
- Main CPU sees a window at the top of the RAM; the sub CPU sees the full array.

---
 rtl/shared_ram_pkg.sv | 21 ++
 rtl/shared_ram_arb_if.sv | 37 +++
 rtl/ram.sv | 32 +++
 rtl/shared_ram_arb.sv | 108 ++++++++++
 tb/tb_shared_ram_arb.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_ram_pkg.sv
// Shared RAM arbiter package.
// Holds the arbiter state and grant encodings and the main-window address
// mapping used by shared_ram_arb.
package shared_ram_pkg;

  typedef enum logic {ST_IDLE, ST_ACC} state_e;
  typedef enum logic {GNT_MAIN, GNT_SUB} gnt_e;

  // Place a main-CPU window address in the top 2^mw locations of a 2^aw RAM.
  // The upper (aw-mw) bits are forced to one. When mw == aw the address
  // passes through unchanged.
  function automatic logic [31:0] main_to_full(input logic [31:0] maddr,
                                               input int unsigned aw,
                                               input int unsigned mw);
    logic [31:0] hi_mask, lo_mask;
    lo_mask = (32'h1 << mw) - 32'h1;
    hi_mask = ((32'h1 << aw) - 32'h1) & ~lo_mask;
    return hi_mask | (maddr & lo_mask);
  endfunction

endpackage

// File: rtl/shared_ram_arb_if.sv
// Main/sub CPU bus bundle for the shared RAM arbiter.
//   M_* : main CPU request/ack/data (window address, MWIN_W bits)
//   S_* : sub CPU request/ack/data (full address, AW bits)
//   BUSY: an access is in flight
// slave  : arbiter side
// master : CPU/requester side
interface shared_ram_arb_if #(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int MWIN_W = 8
);
  logic              M_REQ;
  logic              M_WE;
  logic [MWIN_W-1:0] M_ADDR;
  logic [DW-1:0]     M_DIN;
  logic              M_ACK;
  logic [DW-1:0]     M_DOUT;
  logic              S_REQ;
  logic              S_WE;
  logic [AW-1:0]     S_ADDR;
  logic [DW-1:0]     S_DIN;
  logic              S_ACK;
  logic [DW-1:0]     S_DOUT;
  logic              BUSY;

  modport slave (
    input  M_REQ, M_WE, M_ADDR, M_DIN,
    input  S_REQ, S_WE, S_ADDR, S_DIN,
    output M_ACK, M_DOUT, S_ACK, S_DOUT, BUSY
  );

  modport master (
    output M_REQ, M_WE, M_ADDR, M_DIN,
    output S_REQ, S_WE, S_ADDR, S_DIN,
    input  M_ACK, M_DOUT, S_ACK, S_DOUT, BUSY
  );
endinterface

// File: rtl/ram.sv
// Generic single-port synchronous RAM.
//   clk  : clock, rising edge
//   addr : word address
//   din  : write data
//   q    : registered read data (valid the cycle after a read)
//   wr_n : write strobe, active low
//   rd_n : read strobe, active low
//   ce_n : chip enable, active low; nothing happens when high
// Contents are not reset.
module ram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] q,
  input  logic          wr_n,
  input  logic          rd_n,
  input  logic          ce_n
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (!ce_n) begin
      if (!wr_n)      mem[addr] <= din;
      else if (!rd_n) q         <= mem[addr];
    end
  end

endmodule

// File: rtl/shared_ram_arb.sv
// Dual-CPU shared RAM with a round-robin request/acknowledge arbiter.
//   CLKSYS   : system clock, rising edge
//   RSTn     : synchronous reset, active low
//   SHALTACn : sub-CPU halt acknowledge, active low; low = main exclusive
//   bus      : main/sub request, ack, data and BUSY (shared_ram_arb_if.slave)
// One access per two cycles: grant + RAM access in IDLE, ack (and read
// data capture) in ACC. The main CPU sees the top 2^MWIN_W words.
module shared_ram_arb
  import shared_ram_pkg::*;
#(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int MWIN_W = 8
) (
  input logic              CLKSYS,
  input logic              RSTn,
  input logic              SHALTACn,
  shared_ram_arb_if.slave  bus
);

  state_e        state_q, state_d;
  gnt_e          gnt_q, gnt_d;
  gnt_e          last_q, last_d;
  logic          rd_q, rd_d;
  logic          m_el, s_el;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr, m_full;
  logic [DW-1:0] ram_din, ram_q;
  logic [DW-1:0] m_dout_q, s_dout_q;

  assign m_full = AW'(main_to_full(32'(bus.M_ADDR), AW, MWIN_W));

  // Sub requests while the sub CPU is halted stay pending, not dropped.
  assign m_el = bus.M_REQ;
  assign s_el = bus.S_REQ & SHALTACn;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    rd_d     = rd_q;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = bus.S_ADDR;
    ram_din  = bus.S_DIN;
    case (state_q)
      ST_IDLE: begin
        if (m_el || s_el) begin
          // On a tie the port that did not win last time goes first.
          if (m_el && (!s_el || last_q == GNT_SUB)) gnt_d = GNT_MAIN;
          else                                      gnt_d = GNT_SUB;
          last_d  = gnt_d;
          state_d = ST_ACC;
          ram_en  = 1'b1;
          if (gnt_d == GNT_MAIN) begin
            ram_addr = m_full;
            ram_din  = bus.M_DIN;
            ram_we   = bus.M_WE;
            rd_d     = ~bus.M_WE;
          end else begin
            ram_we   = bus.S_WE;
            rd_d     = ~bus.S_WE;
          end
        end
      end
      ST_ACC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLKSYS) begin
    if (!RSTn) begin
      state_q  <= ST_IDLE;
      gnt_q    <= GNT_MAIN;
      last_q   <= GNT_SUB;
      rd_q     <= 1'b0;
      m_dout_q <= '0;
      s_dout_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      if (state_q == ST_ACC && rd_q) begin
        if (gnt_q == GNT_MAIN) m_dout_q <= ram_q;
        else                   s_dout_q <= ram_q;
      end
    end
  end

  // RAM is held off during reset; an access abandoned by reset never acks.
  ram #(AW, DW) u_ram (
    .clk  (CLKSYS),
    .addr (ram_addr),
    .din  (ram_din),
    .q    (ram_q),
    .wr_n (~ram_we),
    .rd_n (ram_we),
    .ce_n (~(ram_en & RSTn))
  );

  assign bus.M_ACK  = RSTn && state_q == ST_ACC && gnt_q == GNT_MAIN;
  assign bus.S_ACK  = RSTn && state_q == ST_ACC && gnt_q == GNT_SUB;
  assign bus.BUSY   = (state_q == ST_ACC);
  assign bus.M_DOUT = m_dout_q;
  assign bus.S_DOUT = s_dout_q;

endmodule

// File: tb/tb_shared_ram_arb.sv
// Self-checking bench for shared_ram_arb: directed scenarios followed by
// randomized main/sub traffic with random sub-CPU halt windows. A monitor
// predicts ack timing and arbitration order from the access rules, applies
// acked accesses to a memory model in ack order and checks read data.
module tb_shared_ram_arb;
  localparam int AW = 10, DW = 8, MWIN_W = 8;

  typedef struct {
    bit         we;
    int         addr;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rstn, haltn;
  int   checks = 0, failures = 0;

  shared_ram_arb_if #(.AW(AW), .DW(DW), .MWIN_W(MWIN_W)) bus ();

  shared_ram_arb #(.AW(AW), .DW(DW), .MWIN_W(MWIN_W)) dut (
    .CLKSYS   (clk),
    .RSTn     (rstn),
    .SHALTACn (haltn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // reference state
  exp_t       qm[$], qs[$];
  logic [7:0] mem [1024];
  bit         known [1024];
  logic [1:0] exp_ack = 2'b00;   // {main, sub} ack expected this cycle
  bit         last_sub = 1'b1;
  logic [7:0] m_dexp = 8'h00, s_dexp = 8'h00;
  bit         m_known = 1'b0, s_known = 1'b0;
  bit         mdone = 1'b0, sdone = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access (called just after a rising edge), wait for its ack,
  // then drop REQ on the edge ending the ack cycle. lat = cycles until ack.
  task automatic acc(input bit is_m, input bit we, input logic [9:0] addr,
                     input logic [7:0] din, output int lat);
    exp_t e;
    e.we   = we;
    e.data = din;
    e.addr = is_m ? (32'h300 + 32'(addr[7:0])) : 32'(addr);
    if (is_m) begin
      bus.M_REQ = 1'b1; bus.M_WE = we; bus.M_ADDR = addr[7:0]; bus.M_DIN = din;
      qm.push_back(e);
    end else begin
      bus.S_REQ = 1'b1; bus.S_WE = we; bus.S_ADDR = addr; bus.S_DIN = din;
      qs.push_back(e);
    end
    lat = 0;
    forever begin
      @(negedge clk);
      if ((is_m ? bus.M_ACK : bus.S_ACK) === 1'b1) break;
      lat++;
      if (lat > 400) begin
        checks++; failures++;
        $display("FAIL ack_timeout port=%0d actual=no_ack required=ack", is_m);
        break;
      end
    end
    tick();
    if (is_m) bus.M_REQ = 1'b0;
    else      bus.S_REQ = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] act;
    bit         m_el, s_el;
    act = {bus.M_ACK, bus.S_ACK};
    chk("ack", 32'(act), rstn ? 32'(exp_ack) : 32'd0);
    if (rstn === 1'b1) chk("busy", 32'(bus.BUSY), 32'(exp_ack != 2'b00));
    if (m_known) chk("m_dout", 32'(bus.M_DOUT), 32'(m_dexp));
    if (s_known) chk("s_dout", 32'(bus.S_DOUT), 32'(s_dexp));
    if (bus.M_ACK === 1'b1) begin
      if (qm.size() == 0) begin
        checks++; failures++;
        $display("FAIL m_ack_unrequested actual=ack required=none");
      end else begin
        e = qm.pop_front();
        if (e.we) begin mem[e.addr] = e.data; known[e.addr] = 1'b1; end
        else begin m_dexp = mem[e.addr]; m_known = known[e.addr]; end
      end
    end
    if (bus.S_ACK === 1'b1) begin
      if (qs.size() == 0) begin
        checks++; failures++;
        $display("FAIL s_ack_unrequested actual=ack required=none");
      end else begin
        e = qs.pop_front();
        if (e.we) begin mem[e.addr] = e.data; known[e.addr] = 1'b1; end
        else begin s_dexp = mem[e.addr]; s_known = known[e.addr]; end
      end
    end
    if (rstn !== 1'b1) begin
      exp_ack = 2'b00; last_sub = 1'b1;
      m_dexp = 8'h00; s_dexp = 8'h00; m_known = 1'b1; s_known = 1'b1;
      qm.delete(); qs.delete();
    end else if (exp_ack != 2'b00) begin
      exp_ack = 2'b00;              // one access per two cycles
    end else begin
      m_el = (bus.M_REQ === 1'b1);
      s_el = (bus.S_REQ === 1'b1) && (haltn === 1'b1);
      if (m_el && (!s_el || last_sub)) begin exp_ack = 2'b10; last_sub = 1'b0; end
      else if (s_el)                   begin exp_ack = 2'b01; last_sub = 1'b1; end
    end
  end

  initial begin
    int lat, cnt_m, cnt_s;
    bit mdrop;
    logic [7:0] pat_m, pat_s, pat_b;
    exp_t e;

    rstn = 1'b0; haltn = 1'b1;
    bus.M_REQ = 1'b0; bus.M_WE = 1'b0; bus.M_ADDR = '0; bus.M_DIN = '0;
    bus.S_REQ = 1'b0; bus.S_WE = 1'b0; bus.S_ADDR = '0; bus.S_DIN = '0;

    // reset state
    repeat (2) tick();
    chk("rst_m_ack",  32'(bus.M_ACK),  32'd0);
    chk("rst_s_ack",  32'(bus.S_ACK),  32'd0);
    chk("rst_busy",   32'(bus.BUSY),   32'd0);
    chk("rst_m_dout", 32'(bus.M_DOUT), 32'd0);
    chk("rst_s_dout", 32'(bus.S_DOUT), 32'd0);
    rstn = 1'b1;
    repeat (3) tick();

    // sub write/read
    acc(1'b0, 1'b1, 10'h012, 8'hA5, lat); chk("s_wr_lat", 32'(lat), 32'd1);
    acc(1'b0, 1'b0, 10'h012, 8'h00, lat); chk("s_rd_lat", 32'(lat), 32'd1);
    @(negedge clk); chk("s_rd_data", 32'(bus.S_DOUT), 32'hA5);
    tick();

    // window mapping: main 0x05 lands at 0x305
    acc(1'b1, 1'b1, 10'h005, 8'h3C, lat); chk("m_wr_lat", 32'(lat), 32'd1);
    acc(1'b0, 1'b0, 10'h305, 8'h00, lat);
    @(negedge clk); chk("win_map", 32'(bus.S_DOUT), 32'h3C);
    tick();

    // round robin after reset: M, S, M, S
    rstn = 1'b0; tick(); rstn = 1'b1;
    e.we = 1'b0; e.data = 8'h00;
    e.addr = 32'h305; qm.push_back(e); qm.push_back(e);
    e.addr = 32'h012; qs.push_back(e); qs.push_back(e);
    bus.M_REQ = 1'b1; bus.M_WE = 1'b0; bus.M_ADDR = 8'h05;
    bus.S_REQ = 1'b1; bus.S_WE = 1'b0; bus.S_ADDR = 10'h012;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pat_m[k] = bus.M_ACK; pat_s[k] = bus.S_ACK; pat_b[k] = bus.BUSY;
    end
    tick();
    bus.M_REQ = 1'b0; bus.S_REQ = 1'b0;
    chk("rr_m_ack", 32'(pat_m), 32'h22);
    chk("rr_s_ack", 32'(pat_s), 32'h88);
    chk("rr_busy",  32'(pat_b), 32'hAA);
    tick();

    // halt mode: sub held pending while SHALTACn low
    haltn = 1'b0;
    e.addr = 32'h305; qm.push_back(e);
    e.addr = 32'h012; qs.push_back(e);
    bus.M_REQ = 1'b1; bus.M_WE = 1'b0; bus.M_ADDR = 8'h05;
    bus.S_REQ = 1'b1; bus.S_WE = 1'b0; bus.S_ADDR = 10'h012;
    cnt_m = 0; cnt_s = 0; mdrop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.M_ACK === 1'b1) begin cnt_m++; mdrop = 1'b1; end
      if (bus.S_ACK === 1'b1) cnt_s++;
      tick();
      if (mdrop) bus.M_REQ = 1'b0;
    end
    chk("halt_m_acks", 32'(cnt_m), 32'd1);
    chk("halt_s_acks", 32'(cnt_s), 32'd0);
    haltn = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.S_ACK === 1'b1) break;
      lat++;
      if (lat > 20) break;
    end
    chk("halt_release_lat", 32'(lat), 32'd1);
    tick();
    bus.S_REQ = 1'b0;

    // reset during the ACC cycle of a sub read
    e.addr = 32'h012; qs.push_back(e);
    bus.S_REQ = 1'b1; bus.S_WE = 1'b0; bus.S_ADDR = 10'h012;
    tick();
    rstn = 1'b0; bus.S_REQ = 1'b0;
    @(negedge clk); chk("rst_abort_no_ack", 32'(bus.S_ACK), 32'd0);
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_abort_s_dout", 32'(bus.S_DOUT), 32'd0);
    chk("rst_abort_busy",   32'(bus.BUSY),   32'd0);
    tick();
    acc(1'b0, 1'b0, 10'h012, 8'h00, lat); chk("post_rst_lat", 32'(lat), 32'd1);
    @(negedge clk); chk("post_rst_data", 32'(bus.S_DOUT), 32'hA5);
    tick();

    // randomized traffic
    fork
      begin
        int lm;
        for (int i = 0; i < 150; i++) begin
          acc(1'b1, 1'($urandom_range(0, 1)), 10'(8'hF8 | 8'($urandom_range(0, 7))),
              8'($urandom), lm);
          repeat ($urandom_range(0, 3)) tick();
        end
        mdone = 1'b1;
      end
      begin
        int ls;
        logic [9:0] sa;
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) sa = 10'($urandom_range(0, 1023));
          else                           sa = 10'h3F8 | 10'($urandom_range(0, 7));
          acc(1'b0, 1'($urandom_range(0, 1)), sa, 8'($urandom), ls);
          repeat ($urandom_range(0, 3)) tick();
        end
        sdone = 1'b1;
      end
      begin
        while (!(mdone && sdone)) begin
          tick();
          if (haltn == 1'b1) begin
            if ($urandom_range(0, 19) == 0) haltn = 1'b0;
          end else if ($urandom_range(0, 5) == 0) haltn = 1'b1;
        end
        haltn = 1'b1;
      end
    join

    repeat (4) tick();
    chk("queues_drained", 32'(qm.size() + qs.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
